// File: rtl/verin_endstop_conditioner_pkg.sv
// Shared constants for the cylinder end-stop conditioner.
package verin_pkg;

  localparam int CLK_HZ              = 50_000_000;
  // One millisecond of debounce at the system clock rate.
  localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 1000;
  localparam int CNT_W_DEF           = 16;

  // Bit positions of the two end-stop switches on the PIO input port.
  localparam int IDX_RETRACTED = 0;
  localparam int IDX_EXTENDED  = 1;

  // True when the debounce length fits the counter and is at least 2.
  function automatic bit debounce_in_range(input int cycles, input int cnt_w);
    return (cycles >= 2) && (cycles <= (1 << cnt_w) - 1);
  endfunction

endpackage

// File: rtl/verin_endstop_conditioner_if.sv
// Signal bundle between the switch inputs / controller and the conditioner.
interface verin_endstop_conditioner_if #(
  parameter int NB_CH = 2
);
  logic [NB_CH-1:0] raw_in;
  logic             fault_clr;
  logic [NB_CH-1:0] level_out;
  logic [NB_CH-1:0] rise_pulse;
  logic [NB_CH-1:0] fall_pulse;
  logic             fault;

  // Controller / switch side.
  modport master (
    output raw_in, fault_clr,
    input  level_out, rise_pulse, fall_pulse, fault
  );

  // Conditioner side.
  modport slave (
    input  raw_in, fault_clr,
    output level_out, rise_pulse, fall_pulse, fault
  );
endinterface

// File: rtl/verin_endstop_conditioner_debounce_ch.sv
// One switch channel: 2-FF synchronizer, run-length debouncer, edge pulses.
module verin_debounce_ch
  import verin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic x_i,         // raw (already polarity-corrected) switch input
  output logic stable_d_o,  // next stable level, used for the fault look-ahead
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam bit             RANGE_OK = debounce_in_range(DEBOUNCE_CYCLES, CNT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, fall_q;
  logic             differ;

  // Count consecutive cycles of disagreement; accept the new level on the last one.
  always_comb begin
    differ   = s2_q ^ stable_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (differ && (cnt_q == CNT_LAST)) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else if (differ) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer, debounce state and pulses registered on the same edge.
  always_ff @(posedge clk) begin
    assert (RANGE_OK) else $fatal(1, "verin_debounce_ch: DEBOUNCE_CYCLES out of range");
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      s1_q     <= x_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= stable_d & ~stable_q;
      fall_q   <= ~stable_d & stable_q;
    end
  end

  assign stable_d_o = stable_d;
  assign level_o    = stable_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;

endmodule

// File: rtl/verin_endstop_conditioner.sv
// End-stop conditioner: per-channel debounce plus the both-ends-active fault flag.
module verin_endstop_conditioner
  import verin_pkg::*;
#(
  parameter int NB_CH           = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter bit INVERT          = 1'b0
) (
  input logic clk,
  input logic reset,
  verin_endstop_conditioner_if.slave io
);

  logic [NB_CH-1:0] x;
  logic [NB_CH-1:0] stable_d;
  logic [NB_CH-1:0] level;
  logic [NB_CH-1:0] rise;
  logic [NB_CH-1:0] fall;
  logic             fault_q, fault_d;

  // Active-low switches are flipped before they enter the synchronizers.
  assign x = io.raw_in ^ {NB_CH{INVERT}};

  generate
    for (genvar gi = 0; gi < NB_CH; gi++) begin : g_ch
      verin_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_ch (
        .clk        (clk),
        .reset      (reset),
        .x_i        (x[gi]),
        .stable_d_o (stable_d[gi]),
        .level_o    (level[gi]),
        .rise_o     (rise[gi]),
        .fall_o     (fall[gi])
      );
    end
  endgenerate

  // All ends active at once is impossible; the set condition beats a clear request.
  always_comb begin
    fault_d = fault_q;
    if (&stable_d) begin
      fault_d = 1'b1;
    end else if (io.fault_clr) begin
      fault_d = 1'b0;
    end
  end

  // Sticky fault register, looked ahead from next-stable so it rises with level_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign io.level_out  = level;
  assign io.rise_pulse = rise;
  assign io.fall_pulse = fall;
  assign io.fault      = fault_q;

endmodule
